// File: rtl/ifm_rd_sched_if.sv
// Reader command/data, loader write and RAM port bundle for the ifmap read scheduler.
// slave = scheduler side, master = reader/loader/RAM side.
interface ifm_rd_sched_if #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 8
);
    logic                  r0_cmd_valid;
    logic                  r0_cmd_ready;
    logic [ADDR_WIDTH-1:0] r0_cmd_addr;
    logic [LEN_WIDTH-1:0]  r0_cmd_len;
    logic                  r0_data_valid;
    logic [DATA_WIDTH-1:0] r0_data;
    logic                  r0_data_last;

    logic                  r1_cmd_valid;
    logic                  r1_cmd_ready;
    logic [ADDR_WIDTH-1:0] r1_cmd_addr;
    logic [LEN_WIDTH-1:0]  r1_cmd_len;
    logic                  r1_data_valid;
    logic [DATA_WIDTH-1:0] r1_data;
    logic                  r1_data_last;

    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  ram_read_req;
    logic [ADDR_WIDTH-1:0] ram_read_addr;
    logic [DATA_WIDTH-1:0] ram_read_data;
    logic                  ram_write_req;
    logic [ADDR_WIDTH-1:0] ram_write_addr;
    logic [DATA_WIDTH-1:0] ram_write_data;

    logic                  busy;

    modport slave (
        input  r0_cmd_valid, r0_cmd_addr, r0_cmd_len,
        output r0_cmd_ready, r0_data_valid, r0_data, r0_data_last,
        input  r1_cmd_valid, r1_cmd_addr, r1_cmd_len,
        output r1_cmd_ready, r1_data_valid, r1_data, r1_data_last,
        input  wr_valid, wr_addr, wr_data,
        output ram_read_req, ram_read_addr,
        input  ram_read_data,
        output ram_write_req, ram_write_addr, ram_write_data,
        output busy
    );

    modport master (
        output r0_cmd_valid, r0_cmd_addr, r0_cmd_len,
        input  r0_cmd_ready, r0_data_valid, r0_data, r0_data_last,
        output r1_cmd_valid, r1_cmd_addr, r1_cmd_len,
        input  r1_cmd_ready, r1_data_valid, r1_data, r1_data_last,
        output wr_valid, wr_addr, wr_data,
        input  ram_read_req, ram_read_addr,
        output ram_read_data,
        input  ram_write_req, ram_write_addr, ram_write_data,
        input  busy
    );
endinterface

// File: rtl/ifm_rd_sched.sv
// Round-robin two-reader burst scheduler for the ifmap RAM; cmd accept to first data 3 cycles.
// Commands held off by cmd_ready while a burst runs; read data has no backpressure; loader writes always pass.
module ifm_rd_sched #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst,
    ifm_rd_sched_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic vld;
        logic owner;
        logic last;
    } tag_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    // Owner of the last accepted burst; doubles as the round-robin pointer.
    logic                  owner_q, owner_d;
    tag_t                  tag1_q, tag2_q, tag_in;
    logic                  grant0, grant1, stall, issue;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        stall   = 1'b0;
        issue   = 1'b0;
        tag_in  = '0;
        case (state_q)
            IDLE: begin
                if (bus.r0_cmd_valid && (!bus.r1_cmd_valid || owner_q)) begin
                    grant0 = 1'b1;
                end else if (bus.r1_cmd_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_d = RUN;
                    owner_d = grant1;
                    addr_d  = grant1 ? bus.r1_cmd_addr : bus.r0_cmd_addr;
                    cnt_d   = grant1 ? bus.r1_cmd_len  : bus.r0_cmd_len;
                end
            end
            RUN: begin
                // A same-cycle write to the read address would return stale data; retry next cycle.
                stall = bus.wr_valid && (bus.wr_addr == addr_q);
                issue = !stall;
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    tag_in = '{vld: 1'b1, owner: owner_q, last: (cnt_q == '0)};
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            owner_q <= 1'b1;
            tag1_q  <= '0;
            tag2_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            tag1_q  <= tag_in;
            tag2_q  <= tag1_q;
        end
    end

    assign bus.r0_cmd_ready  = grant0 && !rst;
    assign bus.r1_cmd_ready  = grant1 && !rst;

    assign bus.ram_read_req  = issue && !rst;
    assign bus.ram_read_addr = rst ? '0 : addr_q;

    assign bus.r0_data       = bus.ram_read_data;
    assign bus.r1_data       = bus.ram_read_data;
    assign bus.r0_data_valid = !rst && tag2_q.vld && !tag2_q.owner;
    assign bus.r1_data_valid = !rst && tag2_q.vld &&  tag2_q.owner;
    assign bus.r0_data_last  = bus.r0_data_valid && tag2_q.last;
    assign bus.r1_data_last  = bus.r1_data_valid && tag2_q.last;

    assign bus.ram_write_req  = bus.wr_valid;
    assign bus.ram_write_addr = bus.wr_addr;
    assign bus.ram_write_data = bus.wr_data;

    assign bus.busy = !rst && ((state_q == RUN) || tag1_q.vld || tag2_q.vld);
endmodule
